// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and constants for the regfile write arbiter
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FORCE
    } arb_state_t;

    typedef struct packed {
        logic [4:0]  regNum;
        logic [31:0] data;
    } wr_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired in the regfile, so writes to it are dropped rather than issued
    function automatic logic isWritable(input logic [4:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - CPU writeback, game request and regfile write bundle
interface regfile_write_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          cpu_we;
    logic [4:0]    cpu_reg;
    logic [31:0]   cpu_data;
    logic          cpu_stall;
    logic          game_valid;
    logic          game_ready;
    logic [4:0]    game_reg;
    logic [31:0]   game_data;
    logic          arb_we;
    logic [4:0]    arb_reg;
    logic [31:0]   arb_data;
    logic [CW-1:0] fifo_count;
    logic          err_sticky;

    modport master (
        output cpu_we, cpu_reg, cpu_data, game_valid, game_reg, game_data,
        input  cpu_stall, game_ready, arb_we, arb_reg, arb_data, fifo_count, err_sticky
    );

    modport slave (
        input  cpu_we, cpu_reg, cpu_data, game_valid, game_reg, game_data,
        output cpu_stall, game_ready, arb_we, arb_reg, arb_data, fifo_count, err_sticky
    );

endinterface

// File: rtl/regfile_arb_fifo.sv
// rtl/regfile_arb_fifo.sv - synchronous FIFO of buffered game write requests
module regfile_arb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          push,
    input  wr_req_t       pushData,
    input  logic          pop,
    output wr_req_t       headData,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wr_req_t       mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between CPU writeback and game logic
// Optional macro REGFILE_ARB_PROTECT_EN restricts game writes to [GAME_REG_LO, GAME_REG_HI].
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [4:0] GAME_REG_LO  = 5'd29,
    parameter logic [4:0] GAME_REG_HI  = 5'd29
) (
    input logic                    clock,
    input logic                    ctrl_reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT - 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (STARVE_LIMIT < 1) || (GAME_REG_LO > GAME_REG_HI)) begin : gBadParam
        $error("regfile_write_arbiter: illegal parameter combination");
    end

    arb_state_t    state;
    arb_state_t    stateNext;
    logic [WW-1:0] waitCnt;
    logic [WW-1:0] waitNext;
    wr_req_t       head;
    wr_req_t       gameReq;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] count;
    logic          cpuOwns;
    logic          pop;
    logic          push;
    logic          pushOk;
    logic          lastEntry;
    logic          stallQ;
    logic          arbWe;
    logic [4:0]    arbReg;
    logic [31:0]   arbData;

    assign cpuOwns        = bus.cpu_we && isWritable(bus.cpu_reg);
    assign pop            = !cpuOwns && !fifoEmpty;
    assign bus.game_ready = !fifoFull;
    assign push           = bus.game_valid && bus.game_ready && pushOk;
    assign lastEntry      = pop && (count == CW'(1)) && !push;
    assign gameReq        = '{regNum: bus.game_reg, data: bus.game_data};

`ifdef REGFILE_ARB_PROTECT_EN
    logic errQ;

    // Out-of-range requests are handshaken so the producer never stalls, then dropped
    assign pushOk = (bus.game_reg >= GAME_REG_LO) && (bus.game_reg <= GAME_REG_HI);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            errQ <= 1'b0;
        end else if (bus.game_valid && bus.game_ready && !pushOk) begin
            errQ <= 1'b1;
        end
    end

    assign bus.err_sticky = errQ;
`else
    assign pushOk         = 1'b1;
    assign bus.err_sticky = 1'b0;
`endif

    regfile_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (push),
        .pushData   (gameReq),
        .pop        (pop),
        .headData   (head),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .count      (count)
    );

    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        case (state)
            IDLE: begin
                if (push) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    waitNext = '0;
                    if (lastEntry) begin
                        stateNext = IDLE;
                    end
                end else if (cpuOwns) begin
                    waitNext = waitCnt + WW'(1);
                    if (waitNext >= WAIT_MAX) begin
                        stateNext = FORCE;
                    end
                end
            end
            FORCE: begin
                // A CPU that ignores the stall keeps the slot; we hold FORCE until the head gets out
                if (pop) begin
                    waitNext  = '0;
                    stateNext = lastEntry ? IDLE : DRAIN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state   <= IDLE;
            waitCnt <= '0;
            stallQ  <= 1'b0;
            arbWe   <= 1'b0;
            arbReg  <= REG_ZERO;
            arbData <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            stallQ  <= (stateNext == FORCE);
            if (cpuOwns) begin
                arbWe   <= 1'b1;
                arbReg  <= bus.cpu_reg;
                arbData <= bus.cpu_data;
            end else if (pop && isWritable(head.regNum)) begin
                arbWe   <= 1'b1;
                arbReg  <= head.regNum;
                arbData <= head.data;
            end else begin
                arbWe   <= 1'b0;
                arbReg  <= REG_ZERO;
                arbData <= '0;
            end
        end
    end

    assign bus.cpu_stall  = stallQ;
    assign bus.arb_we     = arbWe;
    assign bus.arb_reg    = arbReg;
    assign bus.arb_data   = arbData;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef REGFILE_ARB_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clock = 1'b0;
    logic ctrl_reset = 1'b0;
    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    regfile_write_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .GAME_REG_LO  (5'd29),
        .GAME_REG_HI  (5'd29)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending game writes plus the age of the current head
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          headAge = 0;
    bit          stallExp = 1'b0;
    bit          expWe = 1'b0;
    bit          errExp = 1'b0;
    logic [4:0]  expReg = '0;
    logic [31:0] expData = '0;
    int          sz;
    bit          cpuWins;
    bit          popped;

    always @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            q.delete();
            headAge  = 0;
            stallExp = 1'b0;
            expWe    = 1'b0;
            errExp   = 1'b0;
        end else begin
            sz      = q.size();
            cpuWins = bus.cpu_we && (bus.cpu_reg != 5'd0);
            popped  = !cpuWins && (sz > 0);
            expWe   = 1'b0;
            if (cpuWins) begin
                expWe   = 1'b1;
                expReg  = bus.cpu_reg;
                expData = bus.cpu_data;
            end else if (popped && q[0].r != 5'd0) begin
                expWe   = 1'b1;
                expReg  = q[0].r;
                expData = q[0].d;
            end
            if (stallExp) begin
                if (popped) begin
                    stallExp = 1'b0;
                    headAge  = 0;
                end
            end else if (sz > 0) begin
                if (popped) begin
                    headAge = 0;
                end else begin
                    headAge++;
                    if (headAge >= LIMIT - 1) stallExp = 1'b1;
                end
            end
            if (popped) void'(q.pop_front());
            if (bus.game_valid && sz < DEPTH) begin
                if (PROT && bus.game_reg != 5'd29) errExp = 1'b1;
                else q.push_back('{r: bus.game_reg, d: bus.game_data});
            end
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            check("cyc_arb_we", 32'(bus.arb_we), 32'(expWe));
            if (expWe) begin
                check("cyc_arb_reg", 32'(bus.arb_reg), 32'(expReg));
                check("cyc_arb_data", bus.arb_data, expData);
            end
            check("cyc_cpu_stall", 32'(bus.cpu_stall), 32'(stallExp));
            check("cyc_fifo_count", 32'(bus.fifo_count), 32'(q.size()));
            check("cyc_game_ready", 32'(bus.game_ready), 32'(q.size() < DEPTH));
            check("cyc_err_sticky", 32'(bus.err_sticky), 32'(errExp));
        end
    end

    task automatic step(input bit we, input logic [4:0] cr, input logic [31:0] cd,
                        input bit gv, input logic [4:0] gr, input logic [31:0] gd);
        bus.cpu_we     = we;
        bus.cpu_reg    = cr;
        bus.cpu_data   = cd;
        bus.game_valid = gv;
        bus.game_reg   = gr;
        bus.game_data  = gd;
        @(posedge clock);
        #1;
    endtask

    int stallAt[4];
    int stallN;
    int idx;
    int acceptAt;
    bit pushNow;

    initial begin
        bus.cpu_we = 1'b0; bus.cpu_reg = '0; bus.cpu_data = '0;
        bus.game_valid = 1'b0; bus.game_reg = '0; bus.game_data = '0;
        repeat (2) @(posedge clock);
        #1;
        checkEn = 1'b1;
        check("rst_arb_we", 32'(bus.arb_we), 32'd0);
        check("rst_arb_reg", 32'(bus.arb_reg), 32'd0);
        check("rst_arb_data", bus.arb_data, 32'd0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_err", 32'(bus.err_sticky), 32'd0);
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // CPU only
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check("t1_arb_we", 32'(bus.arb_we), 32'd1);
        check("t1_arb_reg", 32'(bus.arb_reg), 32'd5);
        check("t1_arb_data", bus.arb_data, 32'hDEADBEEF);
        check("t1_game_ready", 32'(bus.game_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0);

        // Game write into an idle slot
        step(0, 0, 0, 1, 5'd29, 32'h7);
        check("t2_push_we", 32'(bus.arb_we), 32'd0);
        check("t2_push_count", 32'(bus.fifo_count), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check("t2_arb_we", 32'(bus.arb_we), 32'd1);
        check("t2_arb_reg", 32'(bus.arb_reg), 32'd29);
        check("t2_arb_data", bus.arb_data, 32'h7);
        check("t2_count", 32'(bus.fifo_count), 32'd0);

        // Contention: stalls every 8 cycles; the stall at cycle 24 is ignored once
        stallN = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.cpu_stall) begin
                if (stallN < 4) stallAt[stallN] = i;
                stallN++;
            end
            if (i == 3) check("t3_count3", 32'(bus.fifo_count), 32'd3);
            step(!bus.cpu_stall || (i == 24), 5'd10, 32'h1000 + i, i < 3, 5'd29, 32'h100 + i);
        end
        check("t3_stall_n", 32'(stallN), 32'd4);
        check("t3_stall0", 32'(stallAt[0]), 32'd8);
        check("t3_stall1", 32'(stallAt[1]), 32'd16);
        check("t3_stall2", 32'(stallAt[2]), 32'd24);
        check("t3_stall3", 32'(stallAt[3]), 32'd25);
        check("t3_empty", 32'(bus.fifo_count), 32'd0);

        // Full FIFO: fifth request waits for the first forced pop
        idx = 0;
        acceptAt = -1;
        for (int i = 0; i < 80 && !(idx == 5 && bus.fifo_count == 0); i++) begin
            if (i == 4) check("t4_ready_low", 32'(bus.game_ready), 32'd0);
            pushNow = (idx < 5) && bus.game_ready;
            if (pushNow && idx == 4) acceptAt = i;
            step(!bus.cpu_stall, 5'd7, 32'h2000 + i, idx < 5, 5'd29, 32'h300 + idx);
            if (pushNow) idx++;
        end
        check("t4_accept5", 32'(acceptAt), 32'd9);
        check("t4_all_pushed", 32'(idx), 32'd5);
        check("t4_drained", 32'(bus.fifo_count), 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // CPU r0 write yields the slot; game r0 write is popped but not issued
        step(1, 5'd3, 32'h33, 1, 5'd29, 32'hAB);
        step(1, 5'd0, 32'h55, 0, 0, 0);
        check("t5_r0_we", 32'(bus.arb_we), 32'd1);
        check("t5_r0_reg", 32'(bus.arb_reg), 32'd29);
        check("t5_r0_data", bus.arb_data, 32'hAB);
        step(0, 0, 0, 1, 5'd0, 32'h77);
        check("t5_g0_count", 32'(bus.fifo_count), PROT ? 32'd0 : 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check("t5_g0_we", 32'(bus.arb_we), 32'd0);
        check("t5_g0_count2", 32'(bus.fifo_count), 32'd0);

        // Reset in the middle of draining
        step(1, 5'd9, 32'h1, 1, 5'd29, 32'hC1);
        step(1, 5'd9, 32'h2, 1, 5'd29, 32'hC2);
        step(1, 5'd9, 32'h3, 0, 0, 0);
        check("t5_pre_count", 32'(bus.fifo_count), 32'd2);
        check("t5_pre_we", 32'(bus.arb_we), 32'd1);
        bus.cpu_we = 1'b0;
        ctrl_reset = 1'b0;
        #1;
        check("t5_rst_we", 32'(bus.arb_we), 32'd0);
        check("t5_rst_count", 32'(bus.fifo_count), 32'd0);
        check("t5_rst_stall", 32'(bus.cpu_stall), 32'd0);
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Protected range
        step(0, 0, 0, 1, 5'd3, 32'h3C);
        step(0, 0, 0, 0, 0, 0);
        check("t6_r3_we", 32'(bus.arb_we), PROT ? 32'd0 : 32'd1);
        check("t6_err", 32'(bus.err_sticky), 32'(PROT));
        step(0, 0, 0, 1, 5'd29, 32'h29);
        step(0, 0, 0, 0, 0, 0);
        check("t6_r29_we", 32'(bus.arb_we), 32'd1);
        check("t6_r29_reg", 32'(bus.arb_reg), 32'd29);
        check("t6_r29_data", bus.arb_data, 32'h29);
        step(0, 0, 0, 0, 0, 0);
        check("t6_err_held", 32'(bus.err_sticky), 32'(PROT));

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
